// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator: sync, blanking,
// display coordinates, frame/line strobes and the lookahead fetch stream.
interface vga_timing_gen_if;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic       line_end;
  logic [9:0] fetch_x;
  logic [9:0] fetch_y;
  logic       fetch_valid;

  modport master (
    output hs, vs, blank_n, DrawX, DrawY, frame_start, line_end,
           fetch_x, fetch_y, fetch_valid
  );

  modport slave (
    input hs, vs, blank_n, DrawX, DrawY, frame_start, line_end,
          fetch_x, fetch_y, fetch_valid
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator on the 25 MHz pixel clock.
// Two free-running position counters: the display position and a fetch
// position running FETCH_LEAD cycles ahead so a fixed-latency pixel lookup
// lands on the right pixel. All outputs are flops loaded with the decode
// of the position being entered, so they never lag DrawX/DrawY.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   FETCH_LEAD  = 2
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME_TOTAL = H_TOTAL * V_TOTAL;

  // Fetch counters park one step before their first displayed position so
  // the first edge after reset lands the fetch pair FETCH_LEAD ahead of (0,0).
  localparam int FETCH_RST   = (FETCH_LEAD == 0) ? FRAME_TOTAL - 1 : FETCH_LEAD - 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] FH_RST   = 10'(FETCH_RST % H_TOTAL);
  localparam logic [9:0] FV_RST   = 10'(FETCH_RST / H_TOTAL);

  function automatic logic is_visible(input logic [9:0] x, input logic [9:0] y);
    return (x < H_VIS) && (y < V_VIS);
  endfunction

  function automatic logic in_hsync(input logic [9:0] x);
    return (x >= HS_START) && (x < HS_END);
  endfunction

  function automatic logic in_vsync(input logic [9:0] y);
    return (y >= VS_START) && (y < VS_END);
  endfunction

  logic [9:0] hc_reg, vc_reg, fhc_reg, fvc_reg;
  logic [9:0] hc_next, vc_next, fhc_next, fvc_next;

  logic       hs_reg, vs_reg, blank_n_reg, frame_start_reg, line_end_reg;
  logic       fetch_valid_reg;
  logic [9:0] draw_x_reg, draw_y_reg, fetch_x_reg, fetch_y_reg;

  // Next display and fetch positions: column wraps at line end, row wraps at frame end.
  always_comb begin
    hc_next  = (hc_reg == H_LAST) ? 10'd0 : hc_reg + 10'd1;
    vc_next  = vc_reg;
    if (hc_reg == H_LAST)
      vc_next = (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;

    fhc_next = (fhc_reg == H_LAST) ? 10'd0 : fhc_reg + 10'd1;
    fvc_next = fvc_reg;
    if (fhc_reg == H_LAST)
      fvc_next = (fvc_reg == V_LAST) ? 10'd0 : fvc_reg + 10'd1;
  end

  // Position counters; reset parks display at the last pixel of the frame.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg  <= H_LAST;
      vc_reg  <= V_LAST;
      fhc_reg <= FH_RST;
      fvc_reg <= FV_RST;
    end else begin
      hc_reg  <= hc_next;
      vc_reg  <= vc_next;
      fhc_reg <= fhc_next;
      fvc_reg <= fvc_next;
    end
  end

  // Output flops take the decode of the position being entered this edge.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_reg          <= ~SYNC_ACTIVE;
      vs_reg          <= ~SYNC_ACTIVE;
      blank_n_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
      draw_x_reg      <= 10'd0;
      draw_y_reg      <= 10'd0;
      fetch_x_reg     <= 10'd0;
      fetch_y_reg     <= 10'd0;
      fetch_valid_reg <= 1'b0;
    end else begin
      hs_reg          <= in_hsync(hc_next) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_reg          <= in_vsync(vc_next) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      blank_n_reg     <= is_visible(hc_next, vc_next);
      frame_start_reg <= (hc_next == 10'd0) && (vc_next == 10'd0);
      line_end_reg    <= (hc_next == H_LAST);
      draw_x_reg      <= hc_next;
      draw_y_reg      <= vc_next;
      fetch_x_reg     <= fhc_next;
      fetch_y_reg     <= fvc_next;
      fetch_valid_reg <= is_visible(fhc_next, fvc_next);
    end
  end

  assign vga.hs          = hs_reg;
  assign vga.vs          = vs_reg;
  assign vga.blank_n     = blank_n_reg;
  assign vga.frame_start = frame_start_reg;
  assign vga.line_end    = line_end_reg;
  assign vga.DrawX       = draw_x_reg;
  assign vga.DrawY       = draw_y_reg;
  assign vga.fetch_x     = fetch_x_reg;
  assign vga.fetch_y     = fetch_y_reg;
  assign vga.fetch_valid = fetch_valid_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size 640x480 instance plus three
// reduced-geometry instances (240x13 frame, 160-cycle horizontal blanking)
// with FETCH_LEAD = 0, 2 and 160, all checked every cycle against a
// frame-arithmetic model, plus directed literal checks.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic reset_n   = 1'b1;
  int   cyc       = -1;   // index of the position entered since reset release
  int   total     = 0;
  int   bad       = 0;

  always #20 pixel_clk = ~pixel_clk;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_z ();
  vga_timing_gen_if if_s2 ();
  vga_timing_gen_if if_l ();

  vga_timing_gen u_def (.pixel_clk(pixel_clk), .reset_n(reset_n), .vga(if_def));

  vga_timing_gen #(.H_VISIBLE(80), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .FETCH_LEAD(0))
    u_z (.pixel_clk(pixel_clk), .reset_n(reset_n), .vga(if_z));

  vga_timing_gen #(.H_VISIBLE(80), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .FETCH_LEAD(2))
    u_s2 (.pixel_clk(pixel_clk), .reset_n(reset_n), .vga(if_s2));

  vga_timing_gen #(.H_VISIBLE(80), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .FETCH_LEAD(160))
    u_l (.pixel_clk(pixel_clk), .reset_n(reset_n), .vga(if_l));

  // Cycle index: -1 while in reset, 0 at the first edge after release.
  always @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  // Model: position = cycle index modulo the frame, decoded with plain arithmetic.
  // Packing: {hs, vs, blank_n, frame_start, line_end, fetch_valid, DrawX, DrawY, fetch_x, fetch_y}
  function automatic logic [45:0] model(int hv, int hf, int hsy, int hb,
                                        int vv, int vf, int vsy, int vb,
                                        int lead, int c);
    int ht, vt, fr, p, x, y, q, fx, fy;
    logic hs, vs, bn, fs, le, fv;
    if (c < 0) return {1'b1, 1'b1, 4'b0000, 40'd0};
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    fr = ht * vt;
    p  = c % fr;
    x  = p % ht;
    y  = p / ht;
    q  = (p + lead) % fr;
    fx = q % ht;
    fy = q / ht;
    hs = !((x >= hv + hf) && (x < hv + hf + hsy));
    vs = !((y >= vv + vf) && (y < vv + vf + vsy));
    bn = (x < hv) && (y < vv);
    fs = (p == 0);
    le = (x == ht - 1);
    fv = (fx < hv) && (fy < vv);
    return {hs, vs, bn, fs, le, fv, 10'(x), 10'(y), 10'(fx), 10'(fy)};
  endfunction

  function automatic logic [45:0] pack(logic hs, logic vs, logic bn, logic fs,
                                       logic le, logic fv, logic [9:0] dx,
                                       logic [9:0] dy, logic [9:0] fx, logic [9:0] fy);
    return {hs, vs, bn, fs, le, fv, dx, dy, fx, fy};
  endfunction

  task automatic cmp_vec(string name, logic [45:0] act, logic [45:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge pixel_clk) begin
    cmp_vec("def", pack(if_def.hs, if_def.vs, if_def.blank_n, if_def.frame_start,
                        if_def.line_end, if_def.fetch_valid, if_def.DrawX, if_def.DrawY,
                        if_def.fetch_x, if_def.fetch_y),
            model(640, 16, 96, 48, 480, 10, 2, 33, 2, cyc));
    cmp_vec("lead0", pack(if_z.hs, if_z.vs, if_z.blank_n, if_z.frame_start,
                          if_z.line_end, if_z.fetch_valid, if_z.DrawX, if_z.DrawY,
                          if_z.fetch_x, if_z.fetch_y),
            model(80, 16, 96, 48, 6, 2, 2, 3, 0, cyc));
    cmp_vec("lead2", pack(if_s2.hs, if_s2.vs, if_s2.blank_n, if_s2.frame_start,
                          if_s2.line_end, if_s2.fetch_valid, if_s2.DrawX, if_s2.DrawY,
                          if_s2.fetch_x, if_s2.fetch_y),
            model(80, 16, 96, 48, 6, 2, 2, 3, 2, cyc));
    cmp_vec("lead160", pack(if_l.hs, if_l.vs, if_l.blank_n, if_l.frame_start,
                            if_l.line_end, if_l.fetch_valid, if_l.DrawX, if_l.DrawY,
                            if_l.fetch_x, if_l.fetch_y),
            model(80, 16, 96, 48, 6, 2, 2, 3, 160, cyc));
  end

  // Frame period and vsync width on the reduced instance: 240*13 = 3120 cycles, 2*240 = 480 low.
  int last_fs = -1;
  int vs_low  = 0;
  always @(negedge pixel_clk) begin
    if (cyc < 0) begin
      last_fs = -1;
      vs_low  = 0;
    end else begin
      if (if_s2.vs == 1'b0) vs_low++;
      if (if_s2.frame_start) begin
        if (last_fs >= 0) begin
          chk("small_frame_period", cyc - last_fs, 3120);
          chk("small_vs_low_cycles", vs_low, 480);
        end
        last_fs = cyc;
        vs_low  = 0;
      end
    end
  end

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  int hs_low, hs_first, hs_last, le_count, le_x, blank_fall, n;

  initial begin
    #5 reset_n = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("rst_DrawX", if_def.DrawX, 0);
    chk("rst_hs", if_def.hs, 1);
    chk("rst_blank_n", if_def.blank_n, 0);
    chk("rst_fetch_x", if_def.fetch_x, 0);

    @(negedge pixel_clk);
    #5 reset_n = 1'b1;

    step();
    chk("first_frame_start", if_def.frame_start, 1);
    chk("first_DrawX", if_def.DrawX, 0);
    chk("first_DrawY", if_def.DrawY, 0);
    chk("first_blank_n", if_def.blank_n, 1);
    chk("first_hs", if_def.hs, 1);
    chk("first_vs", if_def.vs, 1);
    chk("first_fetch_x", if_def.fetch_x, 2);
    chk("first_fetch_valid", if_def.fetch_valid, 1);
    step();
    chk("second_frame_start", if_def.frame_start, 0);

    // Remainder of line 0: DrawX 2..799.
    hs_low = 0; hs_first = -1; hs_last = -1; le_count = 0; le_x = -1; blank_fall = -1;
    for (int i = 2; i < 800; i++) begin
      step();
      if (if_def.hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(if_def.DrawX);
        hs_last = int'(if_def.DrawX);
      end
      if (if_def.line_end) begin
        le_count++;
        le_x = int'(if_def.DrawX);
      end
      if (!if_def.blank_n && blank_fall < 0) blank_fall = int'(if_def.DrawX);
    end
    chk("line0_hs_low_cycles", hs_low, 96);
    chk("line0_hs_first", hs_first, 656);
    chk("line0_hs_last", hs_last, 751);
    chk("line0_line_end_count", le_count, 1);
    chk("line0_line_end_x", le_x, 799);
    chk("line0_blank_fall_x", blank_fall, 640);
    step();
    chk("line1_DrawX", if_def.DrawX, 0);
    chk("line1_DrawY", if_def.DrawY, 1);

    // Frame-end fetch wrap on the reduced FETCH_LEAD=2 instance.
    n = 0;
    while (!(if_s2.DrawX == 10'd238 && if_s2.DrawY == 10'd12) && n < 4000) begin
      step();
      n++;
    end
    chk("small_wrap_reached", n < 4000, 1);
    chk("small_wrap_fetch_x", if_s2.fetch_x, 0);
    chk("small_wrap_fetch_y", if_s2.fetch_y, 0);
    chk("small_wrap_fetch_valid", if_s2.fetch_valid, 1);

    // Fetch crossing the visible edge on the full-size instance.
    n = 0;
    while (!(if_def.DrawX == 10'd638 && if_def.DrawY == 10'd10) && n < 9000) begin
      step();
      n++;
    end
    chk("x638_reached", n < 9000, 1);
    chk("x638_fetch_x", if_def.fetch_x, 640);
    chk("x638_fetch_y", if_def.fetch_y, 10);
    chk("x638_fetch_valid", if_def.fetch_valid, 0);

    // Mid-frame asynchronous reset.
    n = 0;
    while (!(if_def.DrawX == 10'd300 && if_def.DrawY == 10'd11) && n < 2000) begin
      step();
      n++;
    end
    chk("mid_reached", n < 2000, 1);
    #4 reset_n = 1'b0;
    #1;
    chk("mid_rst_DrawX", if_def.DrawX, 0);
    chk("mid_rst_DrawY", if_def.DrawY, 0);
    chk("mid_rst_hs", if_def.hs, 1);
    chk("mid_rst_vs", if_def.vs, 1);
    chk("mid_rst_blank_n", if_def.blank_n, 0);
    chk("mid_rst_fetch_x", if_def.fetch_x, 0);
    chk("mid_rst_fetch_valid", if_def.fetch_valid, 0);
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    #5 reset_n = 1'b1;
    step();
    chk("post_rst_frame_start", if_def.frame_start, 1);
    chk("post_rst_DrawX", if_def.DrawX, 0);
    chk("post_rst_DrawY", if_def.DrawY, 0);
    chk("post_rst_fetch_x", if_def.fetch_x, 2);

    repeat (300) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
